// File: rtl/chan_sel_mux_if.sv
// Handshake bundle for chan_sel_mux: N producer channels in, one registered consumer port out.
// The master side is the surrounding logic (producers and consumer); the slave side is the selector.
interface chan_sel_mux_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/chan_sel_mux.sv
// N-channel registered selector with valid/ready handshaking.
// The channel is chosen by an explicit select or by a round-robin pointer.
module chan_sel_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input logic           clk,
    input logic           rst,
    chan_sel_mux_if.slave bus
);
    localparam int unsigned SELW = $clog2(N);

    logic [WIDTH-1:0] chan_data [N];
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             accept;
    logic             xfer;
    logic [N-1:0]     ready_vec;
    int unsigned      idx;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_chan_q;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign chan_data[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        ready_vec   = '0;
        if (!bus.mode) begin
            // sel values at or above N never match any channel, so they never grant
            for (int unsigned i = 0; i < N; i++) begin
                if (i == 32'(bus.sel) && bus.in_valid[SELW'(i)]) begin
                    grant_valid = 1'b1;
                    grant       = SELW'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = (32'(ptr) + k) % N;
                if (!grant_valid && bus.in_valid[SELW'(idx)]) begin
                    grant_valid = 1'b1;
                    grant       = SELW'(idx);
                end
            end
        end
        grant_data = chan_data[grant];
        accept     = !out_valid_q || bus.out_ready;
        xfer       = rst && accept && grant_valid;
        if (xfer) begin
            ready_vec[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr         <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_chan_q  <= grant;
                if (bus.mode) begin
                    ptr <= (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_chan_sel_mux.sv
// Self-checking bench for chan_sel_mux: directed scenarios followed by random traffic,
// all compared against a behavioural model of the selection rules.
module tb_chan_sel_mux;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 4;
    localparam int unsigned SELW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    chan_sel_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();
    chan_sel_mux #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int fails  = 0;

    int          m_ptr;
    bit          m_ov;
    logic [31:0] m_data;
    int          m_chan;
    logic [31:0] d [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input bit md, input int s, input logic [N-1:0] v);
        if (!md) return (s < int'(N) && v[s]) ? s : -1;
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_ptr + k) % int'(N);
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic step(input bit md, input int s, input logic [N-1:0] v, input bit ordy);
        int g;
        bit acc;
        logic [N-1:0] exp_rdy;
        bus.mode      = md;
        bus.sel       = SELW'(s);
        bus.in_valid  = v;
        bus.out_ready = ordy;
        for (int i = 0; i < int'(N); i++) bus.in_data[i*WIDTH +: WIDTH] = d[i];
        #2;
        g = model_grant(md, s, v);
        acc = !m_ov || ordy;
        exp_rdy = (acc && g >= 0) ? (N'(1) << g) : '0;
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (acc && g >= 0) begin
            m_data = d[g];
            m_chan = g;
            m_ov   = 1'b1;
            if (md) m_ptr = (g + 1) % int'(N);
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_ov));
        check("out_data", 64'(bus.out_data), 64'(m_data));
        check("out_chan", 64'(bus.out_chan), 64'(m_chan));
    endtask

    task automatic model_reset();
        m_ptr = 0; m_ov = 1'b0; m_data = '0; m_chan = 0;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < int'(N); i++) d[i] = 32'h1000_0000 + 32'(i);
        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
        for (int i = 0; i < int'(N); i++) bus.in_data[i*WIDTH +: WIDTH] = d[i];

        // reset held: outputs cleared, no ready even with valid inputs
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_chan", 64'(bus.out_chan), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // round-robin fairness with all channels valid
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < int'(N); i++) d[i] = $urandom;
            step(1'b1, 0, 4'hF, 1'b1);
            check("rr_seq", 64'(bus.out_chan), 64'(k % 4));
        end

        // fixed select of channel 2, then channel 2 drops its valid
        d[2] = 32'hDEADBEEF;
        step(1'b0, 2, 4'hF, 1'b1);
        check("fixed_data", 64'(bus.out_data), 64'h0000_0000_DEAD_BEEF);
        check("fixed_chan", 64'(bus.out_chan), 64'(2));
        step(1'b0, 2, 4'b1011, 1'b1);
        check("fixed_nogrant_valid", 64'(bus.out_valid), 64'(0));

        // skip and wrap: move ptr to 3, then 0101 grants 0 then 2
        step(1'b1, 0, 4'b0100, 1'b1);
        step(1'b1, 0, 4'b0101, 1'b1);
        check("rr_wrap", 64'(bus.out_chan), 64'(0));
        step(1'b1, 0, 4'b0101, 1'b1);
        check("rr_skip", 64'(bus.out_chan), 64'(2));

        // backpressure for 5 cycles, then release loads a new word on the same edge
        for (int i = 0; i < int'(N); i++) d[i] = $urandom;
        step(1'b1, 0, 4'hF, 1'b1);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < int'(N); i++) d[i] = $urandom;
            step(1'b1, 0, 4'hF, 1'b0);
        end
        step(1'b1, 0, 4'hF, 1'b1);
        check("bp_release_chan", 64'(bus.out_chan), 64'(0));

        // mode switch keeps ptr
        step(1'b1, 0, 4'b0010, 1'b1);
        step(1'b0, 0, 4'hF, 1'b1);
        check("switch_fixed_chan", 64'(bus.out_chan), 64'(0));
        step(1'b1, 0, 4'hF, 1'b1);
        check("switch_rr_chan", 64'(bus.out_chan), 64'(2));

        // asynchronous reset mid-stream with out_valid high
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_valid", 64'(bus.out_valid), 64'(0));
        check("async_rst_data", 64'(bus.out_data), 64'(0));
        check("async_rst_chan", 64'(bus.out_chan), 64'(0));
        check("async_rst_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b1, 0, 4'hF, 1'b1);
        check("post_rst_first", 64'(bus.out_chan), 64'(0));

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(N); i++) d[i] = $urandom;
            step(1'($urandom % 2), int'($urandom % N), N'($urandom), ($urandom % 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/chan_sel_mux.md
# chan_sel_mux

Parametrised N-channel, WIDTH-bit registered selector with valid/ready handshaking, generalising the processor's 32-bit two-way word mux. Each cycle it picks one input channel, either by an explicit select (fixed mode) or by round-robin arbitration (RR mode), and moves that channel's word into a single output register. It sits between multiple producers and one consumer, for example between several result sources and a shared writeback or memory-request port.

## Interface
- WIDTH, 32, data width per channel in bits.
- N, 4, channel count; must be ≥2.
- SELW, $clog2(N), select/channel-index width; derived from N and not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- in_valid  in  N  per-channel valid.
- in_data  in  N*WIDTH  channel i occupies in_data[i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel ready; combinational.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered word.
- out_chan  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data.

## Operation
- accept = !out_valid || out_ready. The output register can load this cycle.
- Fixed mode (mode=0):
  - If sel < N and in_valid[sel], then grant = sel.
  - Otherwise there is no grant. sel ≥ N never grants.
- RR mode (mode=1):
  - Internal pointer ptr (SELW bits, range 0..N-1).
  - grant = first i with in_valid[i] = 1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - No grant if in_valid = 0.
- in_ready[i] = rst && accept && grant exists && (grant == i). At most one in_ready bit is high. All in_ready bits are 0 while rst is low.
- Transfer on channel g: in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
- If out_valid && out_ready and there is no transfer: out_valid <= 0. out_data and out_chan hold their last values.
- If out_valid && !out_ready: the output register holds, and all in_ready bits are 0.
- ptr update:
  - On a transfer in RR mode, ptr <= (g == N-1) ? 0 : g+1.
  - In fixed mode, ptr is unchanged.
- mode and sel are sampled combinationally every cycle. A mode change affects the grant in the same cycle. ptr is kept across mode switches.
- Reset (rst low, asynchronous): out_valid=0, out_data=0, out_chan=0, ptr=0. On release, the first transfer can occur at the first rising edge with rst high.

## Timing
- Latency: 1 cycle from transfer edge to out_valid/out_data visible.
- Throughput: 1 word per cycle while out_ready is held high and some channel is granted.
- Back-to-back operation: with out_valid=1 and out_ready=1, a new transfer on the same edge replaces the word, and out_valid stays 1.
- Producer rules:
  - in_data must be stable while in_valid is high until that channel's transfer.
  - The block does not require producers to hold in_valid, but it only moves a word on a transfer.
- Consumer rule: out_data and out_chan are stable while out_valid && !out_ready.
- Reset during operation: any word in flight is dropped, and out_valid falls immediately (asynchronously).

## Test plan
- Reset: assert rst low mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately. After release, RR grants channel 0 first.
- Fixed mode: N=4, sel=2, in_valid=4'b1111, ch2=0xDEADBEEF, out_ready=1 → in_ready=4'b0100, next cycle out_data=0xDEADBEEF, out_chan=2. Then sel=2 with in_valid[2]=0 → no grant, and out_valid drops after one cycle.
- RR fairness: all four channels valid continuously, out_ready=1 → out_chan sequence 0,1,2,3,0,1… with one word per cycle.
- RR skip and wrap: ptr=3, in_valid=4'b0101 → grant 0 (wrap), then ptr=1 → grant 2.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles → in_ready=0, out_data/out_chan frozen. Raising out_ready lets a new transfer load on the same edge.
- Mode switch: in RR mode with ptr=2, switch to fixed mode with sel=0 → channel 0 granted and ptr stays 2. Switch back to RR → grant resumes scanning from channel 2.
